// File: rtl/mb32_div_pkg.sv
// ============================================================================
// Module   : mb32_div_pkg
// Brief    : Shared constants and state encoding for the mb32 signed divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mb32_div_pkg;

   localparam int c_width  = 32;
   localparam int c_iter_w = $clog2(c_width);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      CALC = 2'd2,
      FIX  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mb32_div_step.sv
// ============================================================================
// Module   : mb32_div_step
// Brief    : One restoring-division iteration: shift in a dividend bit, trial
//            subtract the divisor magnitude, keep or restore.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mb32_div_step
   import mb32_div_pkg::*;
#(
   parameter int WIDTH = c_width
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dbit,
   input  logic [WIDTH-1:0] dmag,
   output logic [WIDTH-1:0] rem_next,
   output logic             qbit
);

   logic [WIDTH:0] w_trial;

   // rem < dmag <= 2^(WIDTH-1) keeps the shifted value below 2^WIDTH, so the
   // top bit of the WIDTH+1 bit difference is a reliable borrow.
   assign w_trial  = {rem, dbit} - {1'b0, dmag};
   assign qbit     = ~w_trial[WIDTH];
   assign rem_next = qbit ? w_trial[WIDTH-1:0] : {rem[WIDTH-2:0], dbit};

endmodule

`default_nettype wire

// File: rtl/mb32_div.sv
// ============================================================================
// Module   : mb32_div
// Brief    : Sequential signed restoring divider, 2*WIDTH / WIDTH bits, one
//            quotient bit per cycle with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mb32_div
   import mb32_div_pkg::*;
#(
   parameter int WIDTH = c_width
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero,
   output logic               overflow
);

   localparam int                c_cnt_w  = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(WIDTH - 1);
   localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
   localparam logic [WIDTH-1:0]   c_minmag = {1'b1, {(WIDTH-1){1'b0}}};

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_dvd;
   logic [WIDTH-1:0]     r_dvs;
   logic                 r_neg_n;
   logic                 r_neg_d;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_sh;
   logic [c_cnt_w-1:0]   r_iter;
   logic                 r_err_dz;
   logic                 r_err_ov;

   logic [2*WIDTH-1:0]   w_mag_n;
   logic [WIDTH-1:0]     w_mag_d;
   logic [WIDTH-1:0]     w_hi;
   logic [WIDTH-1:0]     w_lo;
   logic [WIDTH-1:0]     w_rem_nx;
   logic                 w_qbit;
   logic                 w_q_neg;
   logic                 w_late_ov;

   // Unsigned magnitudes; the most negative values map onto 2^(n-1) exactly.
   assign w_mag_n = r_neg_n ? -r_dvd : r_dvd;
   assign w_mag_d = r_neg_d ? -r_dvs : r_dvs;
   assign w_hi    = w_mag_n[2*WIDTH-1:WIDTH];
   assign w_lo    = w_mag_n[WIDTH-1:0];

   assign w_q_neg   = r_neg_n ^ r_neg_d;
   assign w_late_ov = w_q_neg ? (r_sh > c_minmag) : r_sh[WIDTH-1];

   mb32_div_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .rem      (r_rem),
      .dbit     (r_sh[WIDTH-1]),
      .dmag     (w_mag_d),
      .rem_next (w_rem_nx),
      .qbit     (w_qbit)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_dvd       <= '0;
         r_dvs       <= '0;
         r_neg_n     <= 1'b0;
         r_neg_d     <= 1'b0;
         r_rem       <= '0;
         r_sh        <= '0;
         r_iter      <= '0;
         r_err_dz    <= 1'b0;
         r_err_ov    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_dvd    <= dividend;
                  r_dvs    <= divisor;
                  r_neg_n  <= dividend[2*WIDTH-1];
                  r_neg_d  <= divisor[WIDTH-1];
                  r_err_dz <= 1'b0;
                  r_err_ov <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= PREP;
               end
            end
            PREP: begin
               if (r_dvs == '0) begin
                  r_err_dz <= 1'b1;
                  r_state  <= FIX;
               end else if (w_hi >= w_mag_d) begin
                  r_err_ov <= 1'b1;
                  r_state  <= FIX;
               end else begin
                  r_rem   <= w_hi;
                  r_sh    <= w_lo;
                  r_iter  <= '0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               // Dividend bits leave the top of r_sh while quotient bits enter
               // at the bottom, so r_sh ends up holding the quotient magnitude.
               r_rem  <= w_rem_nx;
               r_sh   <= {r_sh[WIDTH-2:0], w_qbit};
               r_iter <= r_iter + c_one;
               if (r_iter == c_last) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               if (r_err_dz) begin
                  quotient    <= '0;
                  remainder   <= '0;
                  div_by_zero <= 1'b1;
                  overflow    <= 1'b0;
               end else if (r_err_ov || w_late_ov) begin
                  quotient    <= '0;
                  remainder   <= '0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b1;
               end else begin
                  quotient    <= w_q_neg ? -r_sh : r_sh;
                  remainder   <= r_neg_n ? -r_rem : r_rem;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mb32_div.sv
// ============================================================================
// Module   : tb_mb32_div
// Brief    : Self-checking bench for mb32_div: arithmetic reference model plus
//            directed vectors with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mb32_div;

   localparam int W = 32;

   logic           CLK      = 1'b0;
   logic           RST      = 1'b1;
   logic           start    = 1'b0;
   logic [2*W-1:0] dividend = '0;
   logic [W-1:0]   divisor  = '0;
   logic           busy;
   logic           done;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           div_by_zero;
   logic           overflow;

   int n_chk  = 0;
   int n_pass = 0;

   // Expectations for the operation in flight (written by the driver only)
   logic [W-1:0] exp_q, exp_r, lit_q, lit_r;
   logic         exp_dz, exp_ov, lit_dz, lit_ov;
   bit           has_lit;
   int           exp_lat;
   int           req_id = 0;
   int           fin_id = 0;

   always #5 CLK = ~CLK;

   mb32_div #(
      .WIDTH       (W)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   // Reference: truncating signed division from magnitudes, plus latency.
   function automatic void model(input logic [2*W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic dz, output logic ov, output int lat);
      logic [63:0] ma, mb, qm, rm;
      logic        qn;
      ma  = a[63] ? -a : a;
      mb  = {32'b0, (b[31] ? -b : b)};
      qn  = a[63] ^ b[31];
      q   = '0;
      r   = '0;
      dz  = 1'b0;
      ov  = 1'b0;
      lat = W + 2;
      if (b == '0) begin
         dz  = 1'b1;
         lat = 2;
      end else begin
         qm = ma / mb;
         rm = ma % mb;
         if (qm >= 64'h1_0000_0000) begin
            ov  = 1'b1;
            lat = 2;
         end else if ((!qn && qm >= 64'h8000_0000) || (qn && qm > 64'h8000_0000)) begin
            ov = 1'b1;
         end else begin
            q = qn ? -qm[31:0] : qm[31:0];
            r = a[63] ? -rm[31:0] : rm[31:0];
         end
      end
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask

   // Compare process: reset values, busy/done protocol, latency and results.
   int seen_id = 0;
   int n       = 0;
   bit active  = 1'b0;

   always @(negedge CLK) begin
      if (RST) begin
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_done", 64'(done), 64'd0);
         check("rst_quotient", 64'(quotient), 64'd0);
         check("rst_remainder", 64'(remainder), 64'd0);
         check("rst_div_by_zero", 64'(div_by_zero), 64'd0);
         check("rst_overflow", 64'(overflow), 64'd0);
         if (active) begin
            active = 1'b0;
            fin_id = seen_id;
         end
      end else begin
         if (!active && seen_id != req_id) begin
            active  = 1'b1;
            seen_id = req_id;
            n       = 0;
         end
         if (active) begin
            if (done) begin
               check("latency", 64'(n), 64'(exp_lat));
               check("busy_at_done", 64'(busy), 64'd0);
               check("quotient", 64'(quotient), 64'(exp_q));
               check("remainder", 64'(remainder), 64'(exp_r));
               check("div_by_zero", 64'(div_by_zero), 64'(exp_dz));
               check("overflow", 64'(overflow), 64'(exp_ov));
               if (has_lit) begin
                  check("lit_quotient", 64'(quotient), 64'(lit_q));
                  check("lit_remainder", 64'(remainder), 64'(lit_r));
                  check("lit_div_by_zero", 64'(div_by_zero), 64'(lit_dz));
                  check("lit_overflow", 64'(overflow), 64'(lit_ov));
               end
               active = 1'b0;
               fin_id = seen_id;
            end else begin
               check("busy_while_running", 64'(busy), 64'd1);
               if (n > exp_lat + 4) begin
                  check("done_timeout", 64'(n), 64'(exp_lat));
                  active = 1'b0;
                  fin_id = seen_id;
               end
            end
            n++;
         end else begin
            check("idle_done", 64'(done), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
         end
      end
   end

   task automatic run(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit lit,
                      input logic [W-1:0] lq, input logic [W-1:0] lr,
                      input logic ldz, input logic lov);
      @(negedge CLK);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      model(a, b, exp_q, exp_r, exp_dz, exp_ov, exp_lat);
      has_lit  = lit;
      lit_q    = lq;
      lit_r    = lr;
      lit_dz   = ldz;
      lit_ov   = lov;
      @(posedge CLK);
      #1 start = 1'b0;
      req_id++;
   endtask

   task automatic wait_fin;
      wait (fin_id == req_id);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge CLK);
      #2 RST = 1'b0;

      run(64'd100, 32'd7, 1, 32'd14, 32'd2, 0, 0);                                   wait_fin;
      run(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 0);     wait_fin;
      run(64'd100, 32'hFFFF_FFF9, 1, 32'hFFFF_FFF2, 32'd2, 0, 0);                     wait_fin;
      run(64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9, 1, 32'd14, 32'hFFFF_FFFE, 0, 0);    wait_fin;
      run(64'h0000_0001_0000_0000, 32'h0001_0000, 1, 32'h0001_0000, 32'd0, 0, 0);     wait_fin;
      run(64'hFFFF_FFFF_8000_0000, 32'd1, 1, 32'h8000_0000, 32'd0, 0, 0);             wait_fin;
      run(64'd12345, 32'd0, 1, 32'd0, 32'd0, 1, 0);                                   wait_fin;
      run(64'h0000_0000_8000_0000, 32'd1, 1, 32'd0, 32'd0, 0, 1);                     wait_fin;
      run(64'h0000_0005_0000_0000, 32'd3, 1, 32'd0, 32'd0, 0, 1);                     wait_fin;
      run(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'd0, 0, 1);             wait_fin;
      run(64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'd0, 0, 1);             wait_fin;
      run(64'h3FFF_FFFF_FFFF_FFFF, 32'h8000_0000, 1, 32'h8000_0001, 32'h7FFF_FFFF, 0, 0); wait_fin;
      run(64'd0, 32'hFFFF_FFFB, 1, 32'd0, 32'd0, 0, 0);                               wait_fin;
      run(64'h1234_5678_9ABC_DEF0, 32'h7FFF_FFFF, 0, '0, '0, 0, 0);                   wait_fin;
      run(64'hFEDC_BA98_7654_3210, 32'h0123_4567, 0, '0, '0, 0, 0);                   wait_fin;

      // A second start while busy must be dropped: one result, no extra done.
      run(64'd1000, 32'd10, 1, 32'd100, 32'd0, 0, 0);
      repeat (10) @(negedge CLK);
      start    = 1'b1;
      dividend = 64'd77;
      divisor  = 32'd0;
      @(negedge CLK);
      start    = 1'b0;
      wait_fin;
      repeat (40) @(negedge CLK);

      // Reset mid-operation abandons it without a done pulse.
      run(64'd5555, 32'd5, 1, 32'd1111, 32'd0, 0, 0);
      repeat (19) @(negedge CLK);
      #2 RST = 1'b1;
      @(negedge CLK);
      #2 RST = 1'b0;
      wait_fin;
      repeat (40) @(negedge CLK);

      run(64'd200, 32'hFFFF_FFF7, 1, 32'hFFFF_FFEA, 32'd2, 0, 0);                     wait_fin;
      repeat (3) @(negedge CLK);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mb32_div.md
Name: mb32_div

Overview:
- Sequential signed divider that inverts the 32-bit radix-4 Booth multiplier datapath.
- Takes a 2*WIDTH-bit product-format dividend and a WIDTH-bit divisor; returns quotient and remainder.
- Used in the multiplier characterisation harness to recover operands from registered products.
- Restoring algorithm, one quotient bit per cycle, start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width; dividend is 2*WIDTH bits; quotient and remainder are WIDTH bits.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2*WIDTH  signed two's-complement dividend
- divisor  input  WIDTH  signed two's-complement divisor
- busy  output  1  high from the edge after start is accepted until the edge that raises done
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder; sign equals dividend sign, or zero
- div_by_zero  output  1  divisor was 0 for the last result
- overflow  output  1  quotient not representable in WIDTH signed bits for the last result

Behaviour:
- Reset: asynchronous, active-high. While RST is high, state = IDLE and busy, done, quotient, remainder, div_by_zero, overflow = 0.
- Reset mid-operation: abandons the operation immediately; no done pulse is produced.
- States: IDLE, PREP, CALC, FIX.
- IDLE:
  - On an edge with start=1, latch dividend and divisor, set sign flags, go to PREP, set busy=1.
  - With start=0, stay in IDLE.
- PREP (edge 1 after accept):
  - Form magnitudes: |dividend| in 2*WIDTH unsigned bits; |divisor| in WIDTH unsigned bits. -2^(2W-1) and -2^(W-1) must be representable.
  - If divisor == 0: set err_dz and go to FIX.
  - Else if upper WIDTH bits of |dividend| >= |divisor|: set err_ov and go to FIX.
  - Otherwise load the partial remainder with the upper half, the shift register with the lower half, and iter = 0; go to CALC.
- CALC: runs WIDTH edges (edges 2..WIDTH+1). Each edge:
  - Form trial = {rem, next dividend bit} minus |divisor|, computed at WIDTH+1 bits.
  - If trial is non-negative, rem = trial and the quotient bit = 1; otherwise restore rem and the quotient bit = 0.
  - After iter == WIDTH-1, go to FIX.
- FIX (edge WIDTH+2 normal; edge 2 on error path):
  - Negate the quotient magnitude if the operand signs differ; negate the remainder magnitude if the dividend is negative.
  - Late overflow (sets overflow) when:
    - the result is positive and the magnitude's MSB = 1, or
    - the result is negative and the magnitude > 2^(W-1).
  - On any error: quotient = 0, remainder = 0, and the matching flag = 1, the other flag = 0.
  - Registered outputs load; done = 1 for one cycle; busy = 0; return to IDLE.
- Latency from the accept edge to done: WIDTH+2 edges normally (34 for WIDTH=32); 2 edges for div_by_zero or pre-check overflow.
- Outputs hold their values until the next FIX.
- start while busy is ignored and not queued. start in the same cycle as done (state FIX) is ignored; it is accepted in the following IDLE cycle.
- Back-to-back operation: the minimum issue interval is WIDTH+3 cycles.

Decomposition:
- Package mb32_div_pkg:
  - WIDTH default constant.
  - State enum {IDLE, PREP, CALC, FIX}.
  - Iteration-counter width, $clog2(WIDTH).
- Sub-module mb32_div_step: combinational single restoring iteration.
  - Inputs: partial remainder (WIDTH), incoming dividend bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
- Top module: FSM, sign handling, error detection, output registers.

Test Plan:
- dividend=100, divisor=7, start pulse -> done 34 edges after accept; quotient=14, remainder=2, flags=0.
- dividend=-100 (0xFFFF_FFFF_FFFF_FF9C), divisor=7 -> quotient=0xFFFF_FFF2 (-14), remainder=0xFFFF_FFFE (-2).
- Product round-trip:
  - dividend=0x0000_0001_0000_0000, divisor=0x0001_0000 -> quotient=0x0001_0000, remainder=0.
  - dividend=0xFFFF_FFFF_8000_0000, divisor=1 -> quotient=0x8000_0000, overflow=0.
- divisor=0, any dividend -> done 2 edges after accept; div_by_zero=1, quotient=0, remainder=0.
- Overflow cases:
  - dividend=0x0000_0000_8000_0000, divisor=1 -> late overflow; done at edge 34, overflow=1.
  - dividend=0x0000_0005_0000_0000, divisor=3 -> pre-check overflow; done at edge 2.
- Handshake and reset:
  - start re-asserted at edge 10 during busy -> ignored; exactly one done pulse.
  - RST pulsed at edge 20 -> all outputs 0, state IDLE, no done; next start completes normally.
